mario_power_ctrl: RTL and testbench
===================================

# mario_power_ctrl

Power-state controller for the player sprite. It turns gameplay events (mushroom, star, enemy hit, fall) into the `level` and `hero` configuration bits consumed by the player sprite block. It also drives the grow/shrink flicker sequence, the star-power timer, the post-damage grace period and the death flag. It sits between the collision/game logic and the player sprite block, and is clocked by the system clock with a one-cycle frame tick as its time base.

## Interface
- `HERO_TICKS`, default 64: frame ticks of star power (1..255).
- `TRANS_TICKS`, default 8: frame ticks of the grow/shrink flicker sequence (2..15).
- `GRACE_TICKS`, default 32: frame ticks of invulnerability after shrinking (1..255).

- `clk`  in  1  system clock.
- `rstn`  in  1  reset, synchronous, active-low.
- `tick`  in  1  one-cycle frame pulse; all timing is counted in ticks.
- `got_mushroom`  in  1  one-cycle pulse.
- `got_star`  in  1  one-cycle pulse.
- `hit_enemy`  in  1  one-cycle pulse.
- `fell`  in  1  one-cycle pulse: player left the screen bottom.
- `level`  out  1  0 = small, 1 = big; goes to the sprite block.
- `hero`  out  1  star power active; goes to the sprite block.
- `freeze`  out  1  game logic halts player and enemy motion while high.
- `invuln`  out  1  `hero` OR grace counter nonzero.
- `dead`  out  1  sticky death flag.
- `hero_remain`  out  8  remaining star ticks.

## Operation
- States: SMALL, GROW, BIG, SHRINK, DEAD. All outputs are registered.
- Reset (`rstn` = 0 at a `clk` edge): state SMALL, `level` = 0, `hero` = 0, `freeze` = 0, `invuln` = 0, `dead` = 0, and `hero_cnt`, `grace_cnt`, `trans_cnt` all 0. Reset overrides everything, mid-transition included.
- Event priority when several pulses arrive in the same cycle: `fell` > `hit_enemy` > `got_star` > `got_mushroom`. Only the highest-priority event that is *applicable* in the current state is acted on. An ignored pulse is dropped, not queued.
- SMALL:
  - `fell` → DEAD.
  - `hit_enemy` with `invuln` = 0 → DEAD. With `invuln` = 1 it is ignored.
  - `got_star` → `hero_cnt` ← `HERO_TICKS`; state is unchanged.
  - `got_mushroom` → GROW: `trans_cnt` ← `TRANS_TICKS`, `level` ← 1, `freeze` ← 1.
- BIG:
  - `fell` → DEAD.
  - `hit_enemy` with `invuln` = 0 → SHRINK: `trans_cnt` ← `TRANS_TICKS`, `level` ← 0, `freeze` ← 1.
  - `got_star` → reload `hero_cnt`.
  - `got_mushroom` is ignored.
- GROW / SHRINK:
  - All events are ignored.
  - On each `tick`: if `trans_cnt` == 1, exit; otherwise decrement `trans_cnt` and toggle `level`.
  - GROW exit → BIG with `level` = 1, `freeze` = 0.
  - SHRINK exit → SMALL with `level` = 0, `freeze` = 0, `grace_cnt` ← `GRACE_TICKS`.
- DEAD: `dead` = 1, `freeze` = 0, `hero` = 0, `grace_cnt` = 0, `level` = 0. DEAD is left only by reset.
- `hero_cnt`:
  - Decrements on `tick` in SMALL/BIG when nonzero. It holds in GROW/SHRINK (star time is paused during the flicker).
  - A star reload in the same cycle as a tick wins; no decrement happens that cycle.
  - `hero` = (`hero_cnt` != 0), registered alongside the counter. `hero_remain` = `hero_cnt`.
- `grace_cnt` decrements on `tick` in SMALL/BIG when nonzero, and saturates at 0.
- `invuln` = (`hero_cnt` != 0) OR (`grace_cnt` != 0), computed from the next-state counter values so it is exact each cycle.

## Timing
- An event pulse at edge N changes state and outputs at edge N (visible in cycle N+1). Latency is one cycle.
- A GROW entered at edge N with `TRANS_TICKS` = 8 lasts exactly 8 ticks.
  - `level` sequence: 1 after entry, toggling at ticks 1–7 (0,1,0,1,0,1,0), then forced to 1 at tick 8, which is the same edge as the BIG transition.
  - SHRINK mirrors this starting from 0 and ends at 0.
- Star power lasts exactly `HERO_TICKS` ticks outside transitions. `hero` falls on the edge where the last tick decrements `hero_cnt` to 0.
- A tick and an event at the same edge are both applied; the state transition uses the pre-edge state.
- `tick` asserted for more than one cycle is counted once per cycle. The producer guarantees single-cycle pulses.

## Test plan
- Reset → all outputs 0, state SMALL. Then `got_mushroom` at edge N → `level` = 1 and `freeze` = 1 at N+1. After 8 ticks: `level` trace 1,0,1,0,1,0,1,0,1 and `freeze` = 0 in BIG.
- BIG, `hit_enemy` → SHRINK (8 ticks) → SMALL with `invuln` = 1 for 32 ticks. A `hit_enemy` at tick 10 is ignored; a `hit_enemy` at tick 33 gives `dead` = 1.
- SMALL, `got_star` → `hero` = 1, `hero_remain` = 64, which counts down to 0 over 64 ticks. A second star at `hero_remain` = 5, coincident with a tick, → `hero_remain` = 64.
- Same-cycle `fell` + `got_mushroom` in SMALL → DEAD. Same-cycle `hit_enemy` + `got_star` in BIG with `invuln` = 0 → SHRINK, no star.
- `got_star` then `got_mushroom` → `hero_remain` frozen during the 8 GROW ticks, then resumes counting. `fell` while `hero` = 1 → `dead` = 1, `hero` = 0.
- Reset asserted mid-GROW (`trans_cnt` = 4) → next cycle SMALL, `level` = 0, `freeze` = 0, all counters 0.

Source files
------------

// File: rtl/mario_power_if.sv
// Event pulses from game logic into the power controller, and the power
// configuration bits it returns to the sprite block and the game logic.
interface mario_power_if;
    // Single-cycle pulses with no valid/ready: each is an event in the cycle it is
    // high. The controller cannot stall them, so a pulse it does not act on is lost.
    logic       tick;
    logic       got_mushroom;
    logic       got_star;
    logic       hit_enemy;
    logic       fell;
    logic       level;
    logic       hero;
    logic       freeze;
    logic       invuln;
    logic       dead;
    logic [7:0] hero_remain;

    modport master (
        output tick, got_mushroom, got_star, hit_enemy, fell,
        input  level, hero, freeze, invuln, dead, hero_remain
    );

    modport slave (
        input  tick, got_mushroom, got_star, hit_enemy, fell,
        output level, hero, freeze, invuln, dead, hero_remain
    );
endinterface

// File: rtl/mario_power_ctrl.sv
// Player power-state controller: small/big size, flicker transitions, star timer,
// post-damage grace period and the sticky death flag.
module mario_power_ctrl #(
    parameter int HERO_TICKS  = 64,
    parameter int TRANS_TICKS = 8,
    parameter int GRACE_TICKS = 32
) (
    input  logic          clk,
    input  logic          rstn,
    mario_power_if.slave  bus,
    output logic [2:0]    state_dbg
);
    typedef enum logic [2:0] {
        SMALL  = 3'd0,
        GROW   = 3'd1,
        BIG    = 3'd2,
        SHRINK = 3'd3,
        DEAD   = 3'd4
    } state_t;

    state_t     state;
    logic [7:0] hero_cnt;
    logic [7:0] grace_cnt;
    logic [7:0] hero_cnt_n;
    logic [7:0] grace_cnt_n;
    logic [3:0] trans_cnt;
    logic       level_q;
    logic       hero_q;
    logic       freeze_q;
    logic       invuln_q;
    logic       dead_q;

    logic active;
    logic do_fell;
    logic do_hit;
    logic do_star;
    logic do_mush;
    logic to_dead;
    logic trans_done;

    // Events only matter in SMALL/BIG; each decode already masks higher-priority
    // events that are applicable, so at most one of them is set.
    assign active     = (state == SMALL) || (state == BIG);
    assign do_fell    = active && bus.fell;
    assign do_hit     = active && !bus.fell && bus.hit_enemy && !invuln_q;
    assign do_star    = active && !bus.fell && !do_hit && bus.got_star;
    assign do_mush    = (state == SMALL) && !bus.fell && !do_hit && !bus.got_star
                        && bus.got_mushroom;
    assign to_dead    = do_fell || (do_hit && (state == SMALL));
    assign trans_done = ((state == GROW) || (state == SHRINK)) && bus.tick
                        && (trans_cnt == 4'd1);

    always_comb begin
        hero_cnt_n = hero_cnt;
        if (to_dead)
            hero_cnt_n = 8'd0;
        else if (do_star)
            hero_cnt_n = 8'(HERO_TICKS);
        else if (active && bus.tick && (hero_cnt != 8'd0))
            hero_cnt_n = hero_cnt - 8'd1;
    end

    always_comb begin
        grace_cnt_n = grace_cnt;
        if (to_dead)
            grace_cnt_n = 8'd0;
        else if (trans_done && (state == SHRINK))
            grace_cnt_n = 8'(GRACE_TICKS);
        else if (active && bus.tick && (grace_cnt != 8'd0))
            grace_cnt_n = grace_cnt - 8'd1;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state     <= SMALL;
            hero_cnt  <= 8'd0;
            grace_cnt <= 8'd0;
            trans_cnt <= 4'd0;
            level_q   <= 1'b0;
            hero_q    <= 1'b0;
            freeze_q  <= 1'b0;
            invuln_q  <= 1'b0;
            dead_q    <= 1'b0;
        end else begin
            hero_cnt  <= hero_cnt_n;
            grace_cnt <= grace_cnt_n;
            hero_q    <= (hero_cnt_n != 8'd0);
            invuln_q  <= (hero_cnt_n != 8'd0) || (grace_cnt_n != 8'd0);
            case (state)
                SMALL, BIG: begin
                    if (to_dead) begin
                        state    <= DEAD;
                        dead_q   <= 1'b1;
                        level_q  <= 1'b0;
                        freeze_q <= 1'b0;
                    end else if (do_hit) begin
                        state     <= SHRINK;
                        trans_cnt <= 4'(TRANS_TICKS);
                        level_q   <= 1'b0;
                        freeze_q  <= 1'b1;
                    end else if (do_mush) begin
                        state     <= GROW;
                        trans_cnt <= 4'(TRANS_TICKS);
                        level_q   <= 1'b1;
                        freeze_q  <= 1'b1;
                    end
                end
                GROW, SHRINK: begin
                    if (trans_done) begin
                        state     <= (state == GROW) ? BIG : SMALL;
                        level_q   <= (state == GROW);
                        freeze_q  <= 1'b0;
                        trans_cnt <= 4'd0;
                    end else if (bus.tick) begin
                        trans_cnt <= trans_cnt - 4'd1;
                        level_q   <= ~level_q;
                    end
                end
                DEAD: begin
                    dead_q   <= 1'b1;
                    level_q  <= 1'b0;
                    freeze_q <= 1'b0;
                end
                default: state <= SMALL;
            endcase
        end
    end

    assign bus.level       = level_q;
    assign bus.hero        = hero_q;
    assign bus.freeze      = freeze_q;
    assign bus.invuln      = invuln_q;
    assign bus.dead        = dead_q;
    assign bus.hero_remain = hero_cnt;
    assign state_dbg       = state;
endmodule

// File: tb/tb_mario_power_ctrl.sv
// Directed bench for mario_power_ctrl: a vector table for single-cycle event
// handling plus hand-written sequences for the multi-tick behaviour.
module tb_mario_power_ctrl;
    logic       clk;
    logic       rstn;
    logic [2:0] state_dbg;
    int         checks;
    int         failures;

    mario_power_if bus();

    mario_power_ctrl #(
        .HERO_TICKS (64),
        .TRANS_TICKS(8),
        .GRACE_TICKS(32)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .bus      (bus.slave),
        .state_dbg(state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // in  = {rstn, tick, got_mushroom, got_star, hit_enemy, fell}
    // out = {level, hero, freeze, invuln, dead}
    typedef struct {
        logic [5:0] in_bits;
        logic [4:0] out_bits;
        logic [7:0] remain;
        logic [2:0] state;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic chk_all(input string name, input logic [4:0] o,
                           input logic [7:0] rem, input logic [2:0] st);
        chk({name, ".level"},  int'(bus.level),       int'(o[4]));
        chk({name, ".hero"},   int'(bus.hero),        int'(o[3]));
        chk({name, ".freeze"}, int'(bus.freeze),      int'(o[2]));
        chk({name, ".invuln"}, int'(bus.invuln),      int'(o[1]));
        chk({name, ".dead"},   int'(bus.dead),        int'(o[0]));
        chk({name, ".remain"}, int'(bus.hero_remain), int'(rem));
        chk({name, ".state"},  int'(state_dbg),       int'(st));
    endtask

    // Drive one cycle of inputs, then return them to idle just after the edge.
    task automatic step(input logic r, input logic t, input logic m,
                        input logic s, input logic h, input logic f);
        rstn             = r;
        bus.tick         = t;
        bus.got_mushroom = m;
        bus.got_star     = s;
        bus.hit_enemy    = h;
        bus.fell         = f;
        @(posedge clk);
        #1;
        rstn             = 1'b1;
        bus.tick         = 1'b0;
        bus.got_mushroom = 1'b0;
        bus.got_star     = 1'b0;
        bus.hit_enemy    = 1'b0;
        bus.fell         = 1'b0;
    endtask

    task automatic do_reset();
        step(0, 0, 0, 0, 0, 0);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) step(1, 1, 0, 0, 0, 0);
    endtask

    initial begin
        checks           = 0;
        failures         = 0;
        rstn             = 1'b0;
        bus.tick         = 1'b0;
        bus.got_mushroom = 1'b0;
        bus.got_star     = 1'b0;
        bus.hit_enemy    = 1'b0;
        bus.fell         = 1'b0;

        vecs[0]  = '{6'b000000, 5'b00000, 8'd0,  3'd0}; // reset
        vecs[1]  = '{6'b100000, 5'b00000, 8'd0,  3'd0}; // idle
        vecs[2]  = '{6'b101001, 5'b00001, 8'd0,  3'd4}; // fell beats mushroom
        vecs[3]  = '{6'b111100, 5'b00001, 8'd0,  3'd4}; // dead ignores events
        vecs[4]  = '{6'b000000, 5'b00000, 8'd0,  3'd0}; // reset leaves DEAD
        vecs[5]  = '{6'b100100, 5'b01010, 8'd64, 3'd0}; // star
        vecs[6]  = '{6'b110000, 5'b01010, 8'd63, 3'd0}; // tick
        vecs[7]  = '{6'b100010, 5'b01010, 8'd63, 3'd0}; // hit while invuln
        vecs[8]  = '{6'b100110, 5'b01010, 8'd64, 3'd0}; // ignored hit, star acts
        vecs[9]  = '{6'b111100, 5'b01010, 8'd64, 3'd0}; // star beats mushroom+tick
        vecs[10] = '{6'b101000, 5'b11110, 8'd64, 3'd1}; // mushroom -> GROW
        vecs[11] = '{6'b100001, 5'b11110, 8'd64, 3'd1}; // fell ignored in GROW
        vecs[12] = '{6'b110000, 5'b01110, 8'd64, 3'd1}; // flicker, star paused
        vecs[13] = '{6'b000000, 5'b00000, 8'd0,  3'd0}; // reset mid-GROW

        for (int v = 0; v < 14; v++) begin
            step(vecs[v].in_bits[5], vecs[v].in_bits[4], vecs[v].in_bits[3],
                 vecs[v].in_bits[2], vecs[v].in_bits[1], vecs[v].in_bits[0]);
            chk_all($sformatf("vec%0d", v), vecs[v].out_bits, vecs[v].remain,
                    vecs[v].state);
        end

        // Grow flicker: 1,0,1,0,1,0,1,0 then 1 in BIG.
        do_reset();
        chk_all("grow_rst", 5'b00000, 8'd0, 3'd0);
        step(1, 0, 1, 0, 0, 0);
        chk_all("grow_entry", 5'b10100, 8'd0, 3'd1);
        for (int i = 1; i <= 8; i++) begin
            step(1, 1, 0, 0, 0, 0);
            if (i < 8) begin
                chk($sformatf("grow_t%0d.level", i), int'(bus.level), (i % 2 == 0) ? 1 : 0);
                chk($sformatf("grow_t%0d.freeze", i), int'(bus.freeze), 1);
            end else begin
                chk_all("grow_done", 5'b10000, 8'd0, 3'd2);
            end
        end

        // Shrink from BIG, then grace period with hits at tick 10 and 33.
        step(1, 0, 0, 0, 1, 0);
        chk_all("shrink_entry", 5'b00100, 8'd0, 3'd3);
        for (int i = 1; i <= 8; i++) begin
            step(1, 1, 0, 0, 0, 0);
            if (i < 8)
                chk($sformatf("shrink_t%0d.level", i), int'(bus.level), (i % 2 == 1) ? 1 : 0);
            else
                chk_all("shrink_done", 5'b00010, 8'd0, 3'd0);
        end
        for (int k = 1; k <= 33; k++) begin
            step(1, 1, 0, 0, (k == 10 || k == 33), 0);
            if (k < 33) begin
                chk($sformatf("grace_k%0d.invuln", k), int'(bus.invuln), (k < 32) ? 1 : 0);
                chk($sformatf("grace_k%0d.dead", k), int'(bus.dead), 0);
            end else begin
                chk_all("grace_hit_dead", 5'b00001, 8'd0, 3'd4);
            end
        end

        // Star countdown with a reload coincident with a tick at remain=5.
        do_reset();
        step(1, 0, 0, 1, 0, 0);
        chk_all("star_load", 5'b01010, 8'd64, 3'd0);
        for (int k = 1; k <= 59; k++) begin
            step(1, 1, 0, 0, 0, 0);
            chk($sformatf("star_a%0d.remain", k), int'(bus.hero_remain), 64 - k);
        end
        step(1, 1, 0, 1, 0, 0);
        chk_all("star_reload", 5'b01010, 8'd64, 3'd0);
        for (int k = 1; k <= 64; k++) begin
            step(1, 1, 0, 0, 0, 0);
            chk($sformatf("star_b%0d.remain", k), int'(bus.hero_remain), 64 - k);
            chk($sformatf("star_b%0d.hero", k), int'(bus.hero), (k < 64) ? 1 : 0);
            chk($sformatf("star_b%0d.invuln", k), int'(bus.invuln), (k < 64) ? 1 : 0);
        end

        // BIG with invuln=0: hit beats star.
        do_reset();
        step(1, 0, 1, 0, 0, 0);
        ticks(8);
        chk_all("big_ready", 5'b10000, 8'd0, 3'd2);
        step(1, 0, 0, 1, 1, 0);
        chk_all("hit_beats_star", 5'b00100, 8'd0, 3'd3);

        // Star time pauses during GROW, resumes in BIG; fell kills hero.
        do_reset();
        step(1, 0, 0, 1, 0, 0);
        step(1, 1, 0, 0, 0, 0);
        chk("pause_pre.remain", int'(bus.hero_remain), 63);
        step(1, 0, 1, 0, 0, 0);
        chk_all("pause_grow", 5'b11110, 8'd63, 3'd1);
        for (int i = 1; i <= 8; i++) begin
            step(1, 1, 0, 0, 0, 0);
            chk($sformatf("pause_t%0d.remain", i), int'(bus.hero_remain), 63);
        end
        chk_all("pause_big", 5'b11010, 8'd63, 3'd2);
        step(1, 1, 0, 0, 0, 0);
        chk("resume.remain", int'(bus.hero_remain), 62);
        step(1, 0, 0, 0, 0, 1);
        chk_all("fell_hero", 5'b00001, 8'd0, 3'd4);

        // Reset with trans_cnt=4 in GROW.
        do_reset();
        step(1, 0, 1, 0, 0, 0);
        ticks(4);
        chk("midgrow.state", int'(state_dbg), 1);
        do_reset();
        chk_all("midgrow_rst", 5'b00000, 8'd0, 3'd0);
        step(1, 1, 0, 0, 0, 0);
        chk_all("midgrow_idle", 5'b00000, 8'd0, 3'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
